// File: rtl/switch_debouncer_if.sv
// ============================================================================
// Module      : switch_debouncer_if
// Description : Switch/operand bundle between the raw switch lines, the
//               debouncer and the adder. Optional change_count port present
//               when SW_CHANGE_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_debouncer_if;
  logic [3:0] A_raw;
  logic [3:0] B_raw;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic       changed;
  logic       stable;
`ifdef SW_CHANGE_COUNT_EN
  logic [7:0] change_count;

  modport master (
    output A_raw, B_raw,
    input  A_out, B_out, changed, stable, change_count
  );
  modport slave (
    input  A_raw, B_raw,
    output A_out, B_out, changed, stable, change_count
  );
`else
  modport master (
    output A_raw, B_raw,
    input  A_out, B_out, changed, stable
  );
  modport slave (
    input  A_raw, B_raw,
    output A_out, B_out, changed, stable
  );
`endif
endinterface

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module      : switch_debouncer
// Description : Two-flop synchroniser plus per-bit counting debouncer for the
//               8 operand switches, with a one-cycle change strobe.
//               Optional macro SW_CHANGE_COUNT_EN adds an 8-bit change counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  switch_debouncer_if.slave  sw
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0] raw_w;
  logic [7:0] s1_q;
  logic [7:0] s2_q;
  logic [7:0] out_w;
  logic [7:0] upd_w;
  logic [7:0] pend_w;
  logic       changed_q;

  assign raw_w = {sw.B_raw, sw.A_raw};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_w;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             mis_w;

    assign mis_w = (s2_q[i] != out_q);

    always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (!mis_w) begin
        cnt_d = '0;
      end else if (cnt_q == C_LIMIT) begin
        // Limit reached: accept the new level and restart from zero.
        out_d = s2_q[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
      end
    end

    assign upd_w[i]  = mis_w && (cnt_q == C_LIMIT);
    assign pend_w[i] = mis_w || (cnt_q != '0);
    assign out_w[i]  = out_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd_w;
    end
  end

`ifdef SW_CHANGE_COUNT_EN
  logic [7:0] change_count_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      change_count_q <= '0;
    end else if (changed_q) begin
      change_count_q <= change_count_q + 8'd1;
    end
  end

  assign sw.change_count = change_count_q;
`endif

  assign sw.A_out   = out_w[3:0];
  assign sw.B_out   = out_w[7:4];
  assign sw.changed = changed_q;
  assign sw.stable  = ~|pend_w;

endmodule

`default_nettype wire
